// File: rtl/axi_hp_wr_pkg.sv
// Shared AXI3 write-channel widths, response codes and the AW control payload
// used by the HP write throttle and its skid buffer.
package axi_hp_wr_pkg;

    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int PROT_W  = 3;
    localparam int CACHE_W = 4;
    localparam int RESP_W  = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    // Address is kept outside the struct so its width can follow ADDR_WIDTH.
    typedef struct packed {
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
        logic [PROT_W-1:0]  prot;
        logic [CACHE_W-1:0] cache;
    } aw_ctrl_t;

    localparam int AW_CTRL_W = $bits(aw_ctrl_t);

    // EXOKAY counts as an error: the DMA never issues exclusive writes.
    function automatic logic resp_is_err(input logic [RESP_W-1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR) || (resp == RESP_EXOKAY);
    endfunction

endpackage

// File: rtl/axi_skid_buf.sv
// Two-entry valid/ready skid buffer (main + overflow register).
// Latency: 1 cycle from input handshake to out_vld; full throughput.
// Backpressure: in_rdy is a flop equal to "overflow empty"; 0 during reset.
module axi_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_dat,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic             out_vld,
    input  logic             out_rdy
);

    logic             main_vld;
    logic             ovf_vld;
    logic [WIDTH-1:0] main_dat;
    logic [WIDTH-1:0] ovf_dat;
    logic             push;
    logic             pop;

    assign push    = in_vld & in_rdy;
    assign pop     = main_vld & out_rdy;
    assign out_vld = main_vld;
    assign out_dat = main_dat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_vld <= 1'b0;
            ovf_vld  <= 1'b0;
            in_rdy   <= 1'b0;
            main_dat <= '0;
            ovf_dat  <= '0;
        end else if (pop || !main_vld) begin
            // Main slot frees up: refill from overflow first to keep ordering.
            in_rdy <= 1'b1;
            if (ovf_vld) begin
                main_vld <= 1'b1;
                main_dat <= ovf_dat;
                ovf_vld  <= 1'b0;
            end else begin
                main_vld <= push;
                if (push) begin
                    main_dat <= in_dat;
                end
            end
        end else if (push) begin
            ovf_vld <= 1'b1;
            ovf_dat <= in_dat;
            in_rdy  <= 1'b0;
        end else begin
            in_rdy <= !ovf_vld;
        end
    end

endmodule

// File: rtl/axi_hp_wr_throttle.sv
// AXI3 HP0 write throttle: caps outstanding bursts, gates W behind issued AW.
// Latency: AW 1 cycle (skid buffer); W and B combinational pass-through.
// Backpressure: AW held at MAX_OUTSTANDING; W blocked with no burst credit.
// Optional stat_bursts/stat_beats counters: define AXI_HP_WR_THROTTLE_STATS_EN.
module axi_hp_wr_throttle
    import axi_hp_wr_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    axi_aclk,
    input  logic                    axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [LEN_W-1:0]        s_axi_awlen,
    input  logic [SIZE_W-1:0]       s_axi_awsize,
    input  logic [BURST_W-1:0]      s_axi_awburst,
    input  logic [PROT_W-1:0]       s_axi_awprot,
    input  logic [CACHE_W-1:0]      s_axi_awcache,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic                    s_axi_bvalid,
    output logic [RESP_W-1:0]       s_axi_bresp,
    input  logic                    s_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [LEN_W-1:0]        m_axi_awlen,
    output logic [SIZE_W-1:0]       m_axi_awsize,
    output logic [BURST_W-1:0]      m_axi_awburst,
    output logic [PROT_W-1:0]       m_axi_awprot,
    output logic [CACHE_W-1:0]      m_axi_awcache,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic                    m_axi_bvalid,
    input  logic [RESP_W-1:0]       m_axi_bresp,
    output logic                    m_axi_bready,
    output logic [3:0]              outstanding,
    output logic                    err_sticky,
    input  logic                    err_clear
`ifdef AXI_HP_WR_THROTTLE_STATS_EN
    ,
    output logic [31:0]             stat_bursts,
    output logic [31:0]             stat_beats
`endif
);

    localparam logic [3:0] MAX_OS = 4'(MAX_OUTSTANDING);

    aw_ctrl_t                        s_ctrl;
    aw_ctrl_t                        m_ctrl;
    logic [ADDR_WIDTH+AW_CTRL_W-1:0] skid_in;
    logic [ADDR_WIDTH+AW_CTRL_W-1:0] skid_out;
    logic                            skid_vld;
    logic                            skid_rdy;
    logic                            aw_allow;
    logic                            aw_hs;
    logic                            w_hs;
    logic                            w_last_hs;
    logic                            b_hs;
    logic                            credit_ok;
    logic [3:0]                      credit;

    assign s_ctrl.len   = s_axi_awlen;
    assign s_ctrl.size  = s_axi_awsize;
    assign s_ctrl.burst = s_axi_awburst;
    assign s_ctrl.prot  = s_axi_awprot;
    assign s_ctrl.cache = s_axi_awcache;
    assign skid_in      = {s_axi_awaddr, s_ctrl};

    axi_skid_buf #(
        .WIDTH (ADDR_WIDTH + AW_CTRL_W)
    ) u_aw_skid (
        .clk     (axi_aclk),
        .rst_n   (axi_aresetn),
        .in_dat  (skid_in),
        .in_vld  (s_axi_awvalid),
        .in_rdy  (s_axi_awready),
        .out_dat (skid_out),
        .out_vld (skid_vld),
        .out_rdy (skid_rdy)
    );

    assign {m_axi_awaddr, m_ctrl} = skid_out;
    assign m_axi_awlen   = m_ctrl.len;
    assign m_axi_awsize  = m_ctrl.size;
    assign m_axi_awburst = m_ctrl.burst;
    assign m_axi_awprot  = m_ctrl.prot;
    assign m_axi_awcache = m_ctrl.cache;

    assign aw_allow      = outstanding < MAX_OS;
    assign m_axi_awvalid = skid_vld & aw_allow;
    assign skid_rdy      = m_axi_awready & aw_allow;
    assign aw_hs         = m_axi_awvalid & m_axi_awready;

    // Credit counts bursts whose address is downstream but whose last beat is not.
    assign credit_ok    = credit != 4'd0;
    assign m_axi_wvalid = s_axi_wvalid & credit_ok;
    assign s_axi_wready = m_axi_wready & credit_ok;
    assign m_axi_wdata  = s_axi_wdata;
    assign m_axi_wstrb  = s_axi_wstrb;
    assign m_axi_wlast  = s_axi_wlast;
    assign w_hs         = m_axi_wvalid & m_axi_wready;
    assign w_last_hs    = w_hs & s_axi_wlast;

    assign s_axi_bvalid = m_axi_bvalid;
    assign s_axi_bresp  = m_axi_bresp;
    assign m_axi_bready = s_axi_bready;
    assign b_hs         = m_axi_bvalid & s_axi_bready;

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            outstanding <= 4'd0;
            credit      <= 4'd0;
            err_sticky  <= 1'b0;
        end else begin
            if (aw_hs && !b_hs) begin
                outstanding <= outstanding + 4'd1;
            end else if (!aw_hs && b_hs && outstanding != 4'd0) begin
                outstanding <= outstanding - 4'd1;
            end

            if (aw_hs && !w_last_hs) begin
                credit <= credit + 4'd1;
            end else if (!aw_hs && w_last_hs) begin
                credit <= credit - 4'd1;
            end

            if (b_hs && resp_is_err(m_axi_bresp)) begin
                err_sticky <= 1'b1;
            end else if (err_clear) begin
                err_sticky <= 1'b0;
            end
        end
    end

    a_no_b_underflow: assert property (@(posedge axi_aclk) disable iff (!axi_aresetn)
        !(b_hs && outstanding == 4'd0));

`ifdef AXI_HP_WR_THROTTLE_STATS_EN
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn || err_clear) begin
            stat_bursts <= 32'd0;
            stat_beats  <= 32'd0;
        end else begin
            if (b_hs) begin
                stat_bursts <= stat_bursts + 32'd1;
            end
            if (w_hs) begin
                stat_beats <= stat_beats + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_hp_wr_throttle.sv
// Directed bench for axi_hp_wr_throttle (MAX_OUTSTANDING = 4); stat counters
// are checked when AXI_HP_WR_THROTTLE_STATS_EN is defined.
module tb_axi_hp_wr_throttle;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn;
    logic [31:0] s_axi_awaddr;
    logic [3:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic [2:0]  s_axi_awprot;
    logic [3:0]  s_axi_awcache;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic        s_axi_bvalid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bready;
    logic [31:0] m_axi_awaddr;
    logic [3:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic [2:0]  m_axi_awprot;
    logic [3:0]  m_axi_awcache;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic        m_axi_bvalid;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bready;
    logic [3:0]  outstanding;
    logic        err_sticky;
    logic        err_clear;
`ifdef AXI_HP_WR_THROTTLE_STATS_EN
    logic [31:0] stat_bursts;
    logic [31:0] stat_beats;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 axi_aclk = ~axi_aclk;

    axi_hp_wr_throttle #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (64),
        .MAX_OUTSTANDING (4)
    ) dut (
        .axi_aclk      (axi_aclk),
        .axi_aresetn   (axi_aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awcache (s_axi_awcache),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bready  (s_axi_bready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awcache (m_axi_awcache),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bready  (m_axi_bready),
        .outstanding   (outstanding),
        .err_sticky    (err_sticky),
        .err_clear     (err_clear)
`ifdef AXI_HP_WR_THROTTLE_STATS_EN
        ,
        .stat_bursts   (stat_bursts),
        .stat_beats    (stat_beats)
`endif
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick;
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic idle_inputs;
        s_axi_awaddr  = 32'h0;
        s_axi_awlen   = 4'd0;
        s_axi_awsize  = 3'd3;
        s_axi_awburst = 2'b01;
        s_axi_awprot  = 3'd0;
        s_axi_awcache = 4'd0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = 64'h0;
        s_axi_wstrb   = 8'hFF;
        s_axi_wlast   = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        err_clear     = 1'b0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        axi_aresetn = 1'b0;
        tick();
        tick();
        axi_aresetn = 1'b1;
        tick();
    endtask

    // Pushes n single-beat AWs back to back and lets them drain downstream.
    task automatic issue_aw(input int n);
        for (int i = 0; i < n; i++) begin
            s_axi_awvalid = 1'b1;
            s_axi_awaddr  = 32'h8000 + 32'(i * 64);
            s_axi_awlen   = 4'd0;
            tick();
        end
        s_axi_awvalid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        axi_aresetn  = 1'b0;
        s_axi_wvalid = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({m_axi_awvalid, s_axi_awready, m_axi_wvalid, s_axi_wready, s_axi_bvalid, err_sticky} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000 (awv,awr,wv,wr,bv,err)",
                     {m_axi_awvalid, s_axi_awready, m_axi_wvalid, s_axi_wready, s_axi_bvalid, err_sticky});
        end
        n_checks++;
        if (outstanding !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_outstanding: got %0d expected 0", outstanding);
        end
        axi_aresetn  = 1'b1;
        s_axi_wvalid = 1'b0;
        tick();
        n_checks++;
        if (s_axi_awready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_awready: got %b expected 1", s_axi_awready);
        end
    endtask

    task automatic test_single_burst;
        int beats;
        apply_reset();
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 32'h0000_1000;
        s_axi_awlen   = 4'd3;
        s_axi_awsize  = 3'd3;
        s_axi_awburst = 2'b01;
        s_axi_awprot  = 3'd2;
        s_axi_awcache = 4'd3;
        #1;
        n_checks++;
        if ({s_axi_awready, m_axi_awvalid} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_aw_accept: got awr,awv=%b expected 10", {s_axi_awready, m_axi_awvalid});
        end
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_awaddr  = 32'hDEAD_BEEF;
        s_axi_wvalid  = 1'b1;
        s_axi_wdata   = 64'h1000;
        s_axi_wlast   = 1'b0;
        #1;
        n_checks++;
        if ({m_axi_awvalid, m_axi_awaddr, m_axi_awlen} !== {1'b1, 32'h0000_1000, 4'd3}) begin
            n_fail++;
            $display("FAIL single_aw_out: got v=%b addr=%h len=%0d expected v=1 addr=00001000 len=3",
                     m_axi_awvalid, m_axi_awaddr, m_axi_awlen);
        end
        n_checks++;
        if ({m_axi_awsize, m_axi_awburst, m_axi_awprot, m_axi_awcache} !== {3'd3, 2'b01, 3'd2, 4'd3}) begin
            n_fail++;
            $display("FAIL single_aw_attr: got %h expected %h",
                     {m_axi_awsize, m_axi_awburst, m_axi_awprot, m_axi_awcache}, {3'd3, 2'b01, 3'd2, 4'd3});
        end
        n_checks++;
        if ({m_axi_wvalid, outstanding} !== {1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL single_w_same_cycle: got wv=%b out=%0d expected wv=0 out=0", m_axi_wvalid, outstanding);
        end
        tick();
        n_checks++;
        if ({m_axi_awvalid, outstanding} !== {1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL single_out_1: got awv=%b out=%0d expected awv=0 out=1", m_axi_awvalid, outstanding);
        end
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            s_axi_wdata = 64'h1000 + 64'(i);
            s_axi_wlast = (i == 3);
            #1;
            if (m_axi_wvalid && m_axi_wready) beats++;
            n_checks++;
            if ({m_axi_wdata, m_axi_wlast, m_axi_wstrb} !== {64'h1000 + 64'(i), i == 3, 8'hFF}) begin
                n_fail++;
                $display("FAIL single_beat%0d: got data=%h last=%b expected data=%h last=%b",
                         i, m_axi_wdata, m_axi_wlast, 64'h1000 + 64'(i), i == 3);
            end
            tick();
        end
        n_checks++;
        if (beats !== 4) begin
            n_fail++;
            $display("FAIL single_beat_count: got %0d expected 4", beats);
        end
        s_axi_wlast = 1'b0;
        #1;
        n_checks++;
        if (m_axi_wvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_credit_spent: got wv=%b expected 0", m_axi_wvalid);
        end
        s_axi_wvalid = 1'b0;
        m_axi_bvalid = 1'b1;
        #1;
        n_checks++;
        if ({s_axi_bvalid, outstanding} !== {1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL single_b_pass: got bv=%b out=%0d expected bv=1 out=1", s_axi_bvalid, outstanding);
        end
        tick();
        m_axi_bvalid = 1'b0;
        #1;
        n_checks++;
        if ({outstanding, err_sticky} !== {4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_out_0: got out=%0d err=%b expected out=0 err=0", outstanding, err_sticky);
        end
`ifdef AXI_HP_WR_THROTTLE_STATS_EN
        n_checks++;
        if ({stat_bursts, stat_beats} !== {32'd1, 32'd4}) begin
            n_fail++;
            $display("FAIL single_stats: got bursts=%0d beats=%0d expected 1 4", stat_bursts, stat_beats);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int pushed;
        int mhs;
        int wbeats;
        apply_reset();
        pushed = 0;
        mhs    = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            s_axi_awvalid = (pushed < 6);
            s_axi_awaddr  = 32'h2000 + 32'(pushed * 64);
            #1;
            if (m_axi_awvalid && m_axi_awready) begin
                n_checks++;
                if (m_axi_awaddr !== 32'h2000 + 32'(mhs * 64)) begin
                    n_fail++;
                    $display("FAIL b2b_order%0d: got %h expected %h", mhs, m_axi_awaddr, 32'h2000 + 32'(mhs * 64));
                end
                mhs++;
            end
            if (s_axi_awvalid && s_axi_awready) pushed++;
            tick();
        end
        s_axi_awvalid = 1'b0;
        #1;
        n_checks++;
        if (mhs !== 4 || pushed !== 6) begin
            n_fail++;
            $display("FAIL b2b_counts: got m_hs=%0d pushed=%0d expected 4 6", mhs, pushed);
        end
        n_checks++;
        if ({outstanding, m_axi_awvalid, s_axi_awready} !== {4'd4, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_throttled: got out=%0d awv=%b awr=%b expected 4 0 0",
                     outstanding, m_axi_awvalid, s_axi_awready);
        end
        wbeats       = 0;
        s_axi_wvalid = 1'b1;
        s_axi_wlast  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (m_axi_wvalid && m_axi_wready) wbeats++;
            tick();
        end
        s_axi_wvalid = 1'b0;
        n_checks++;
        if (wbeats !== 4) begin
            n_fail++;
            $display("FAIL b2b_w_beats: got %0d expected 4", wbeats);
        end
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        #1;
        n_checks++;
        if ({outstanding, m_axi_awvalid, m_axi_awaddr} !== {4'd3, 1'b1, 32'h2100}) begin
            n_fail++;
            $display("FAIL b2b_release: got out=%0d awv=%b addr=%h expected 3 1 00002100",
                     outstanding, m_axi_awvalid, m_axi_awaddr);
        end
        tick();
        n_checks++;
        if ({outstanding, m_axi_awvalid, s_axi_awready, m_axi_awaddr} !== {4'd4, 1'b0, 1'b1, 32'h2140}) begin
            n_fail++;
            $display("FAIL b2b_refill: got out=%0d awv=%b awr=%b addr=%h expected 4 0 1 00002140",
                     outstanding, m_axi_awvalid, s_axi_awready, m_axi_awaddr);
        end
    endtask

    task automatic test_aw_b_same_cycle;
        apply_reset();
        issue_aw(2);
        s_axi_wvalid = 1'b1;
        s_axi_wlast  = 1'b1;
        tick();
        tick();
        s_axi_wvalid  = 1'b0;
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 32'h3000;
        tick();
        s_axi_awvalid = 1'b0;
        m_axi_bvalid  = 1'b1;
        #1;
        n_checks++;
        if ({m_axi_awvalid, s_axi_bvalid, outstanding} !== {1'b1, 1'b1, 4'd2}) begin
            n_fail++;
            $display("FAIL same_cycle_setup: got awv=%b bv=%b out=%0d expected 1 1 2",
                     m_axi_awvalid, s_axi_bvalid, outstanding);
        end
        tick();
        m_axi_bvalid = 1'b0;
        #1;
        n_checks++;
        if ({outstanding, m_axi_awvalid} !== {4'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL same_cycle_out: got out=%0d awv=%b expected 2 0", outstanding, m_axi_awvalid);
        end
    endtask

    task automatic test_w_early;
        apply_reset();
        s_axi_wvalid = 1'b1;
        s_axi_wdata  = 64'hA5A5_0000_5A5A;
        s_axi_wlast  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if ({m_axi_wvalid, s_axi_wready} !== 2'b00) begin
                n_fail++;
                $display("FAIL w_early_blocked%0d: got wv,wr=%b expected 00", i, {m_axi_wvalid, s_axi_wready});
            end
            tick();
        end
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 32'h4000;
        s_axi_awlen   = 4'd0;
        tick();
        s_axi_awvalid = 1'b0;
        #1;
        n_checks++;
        if ({m_axi_awvalid, m_axi_wvalid} !== 2'b10) begin
            n_fail++;
            $display("FAIL w_early_aw_cycle: got awv,wv=%b expected 10", {m_axi_awvalid, m_axi_wvalid});
        end
        tick();
        n_checks++;
        if ({m_axi_wvalid, s_axi_wready, m_axi_wdata} !== {1'b1, 1'b1, 64'hA5A5_0000_5A5A}) begin
            n_fail++;
            $display("FAIL w_early_release: got wv=%b wr=%b data=%h expected 1 1 0000a5a500005a5a",
                     m_axi_wvalid, s_axi_wready, m_axi_wdata);
        end
        tick();
        n_checks++;
        if (m_axi_wvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL w_early_single: got wv=%b expected 0", m_axi_wvalid);
        end
        s_axi_wvalid = 1'b0;
    endtask

    task automatic test_err_sticky;
        apply_reset();
        issue_aw(4);
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'b10;
        tick();
        m_axi_bvalid = 1'b0;
        #1;
        n_checks++;
        if ({err_sticky, outstanding} !== {1'b1, 4'd3}) begin
            n_fail++;
            $display("FAIL err_slverr: got err=%b out=%0d expected 1 3", err_sticky, outstanding);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        n_checks++;
        if (err_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got %b expected 0", err_sticky);
        end
        err_clear    = 1'b1;
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'b10;
        tick();
        err_clear    = 1'b0;
        m_axi_bvalid = 1'b0;
        n_checks++;
        if (err_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set_wins: got %b expected 1", err_sticky);
        end
        err_clear = 1'b1;
        tick();
        err_clear    = 1'b0;
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'b01;
        tick();
        m_axi_bvalid = 1'b0;
        n_checks++;
        if (err_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL err_exokay: got %b expected 1", err_sticky);
        end
        err_clear = 1'b1;
        tick();
        err_clear    = 1'b0;
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'b00;
        tick();
        m_axi_bvalid = 1'b0;
        n_checks++;
        if ({err_sticky, outstanding} !== {1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL err_okay: got err=%b out=%0d expected 0 0", err_sticky, outstanding);
        end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        issue_aw(3);
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'b10;
        tick();
        m_axi_bvalid = 1'b0;
        s_axi_wvalid = 1'b1;
        s_axi_wlast  = 1'b1;
        tick();
        tick();
        s_axi_wlast   = 1'b0;
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 32'h5000;
        #1;
        n_checks++;
        if ({outstanding, err_sticky, m_axi_wvalid} !== {4'd2, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_setup: got out=%0d err=%b wv=%b expected 2 1 1", outstanding, err_sticky, m_axi_wvalid);
        end
        axi_aresetn = 1'b0;
        tick();
        axi_aresetn = 1'b1;
        n_checks++;
        if ({m_axi_awvalid, s_axi_awready, m_axi_wvalid, s_axi_wready, s_axi_bvalid, err_sticky} !== 6'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ctrl: got %b expected 000000 (awv,awr,wv,wr,bv,err)",
                     {m_axi_awvalid, s_axi_awready, m_axi_wvalid, s_axi_wready, s_axi_bvalid, err_sticky});
        end
        n_checks++;
        if (outstanding !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset_out: got %0d expected 0", outstanding);
        end
`ifdef AXI_HP_WR_THROTTLE_STATS_EN
        n_checks++;
        if ({stat_bursts, stat_beats} !== 64'd0) begin
            n_fail++;
            $display("FAIL mid_reset_stats: got bursts=%0d beats=%0d expected 0 0", stat_bursts, stat_beats);
        end
`endif
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({m_axi_awvalid, s_axi_awready} !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_reset_empty: got awv,awr=%b expected 01", {m_axi_awvalid, s_axi_awready});
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_aw_b_same_cycle();
        test_w_early();
        test_err_sticky();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the end of the test sequence");
        $fatal(1);
    end

endmodule

// File: doc/axi_hp_wr_throttle.md
Name: axi_hp_wr_throttle

Overview:
- Sits between the ADC DMA write master (AXI3, 4-bit AWLEN) and the PS HP0 slave port.
- Registers the AW channel and caps outstanding write bursts at MAX_OUTSTANDING.
- Gates W beats so data never runs ahead of an address already issued downstream.
- Reports outstanding count and a sticky error flag for non-OKAY write responses.

Parameters:
- ADDR_WIDTH, 32, AW address width
- DATA_WIDTH, 64, W data width; strobe width is DATA_WIDTH/8
- MAX_OUTSTANDING, 4, maximum AW issued downstream without a completed B (range 1..15)

Ports:
- axi_aclk  in  1  single clock
- axi_aresetn  in  1  synchronous, active-low reset
- s_axi_awaddr/awlen/awsize/awburst/awprot/awcache  in  ADDR_WIDTH/4/3/2/3/4  upstream AW payload
- s_axi_awvalid  in  1 ; s_axi_awready  out  1
- s_axi_wdata  in  DATA_WIDTH ; s_axi_wstrb  in  DATA_WIDTH/8 ; s_axi_wlast  in  1 ; s_axi_wvalid  in  1 ; s_axi_wready  out  1
- s_axi_bvalid  out  1 ; s_axi_bresp  out  2 ; s_axi_bready  in  1
- m_axi_aw*  out  same widths as s_axi_aw*  downstream AW payload ; m_axi_awvalid  out  1 ; m_axi_awready  in  1
- m_axi_wdata/wstrb/wlast/wvalid  out ; m_axi_wready  in
- m_axi_bvalid  in  1 ; m_axi_bresp  in  2 ; m_axi_bready  out  1
- outstanding  out  4  AWs issued downstream with B not yet returned
- err_sticky  out  1  set on any B handshake with bresp != 2'b00
- err_clear  in  1  clears err_sticky

Behaviour:
- Reset, while axi_aresetn is low at a clock edge:
  - All m_*valid, s_*ready, s_axi_bvalid and err_sticky are 0.
  - outstanding and the internal burst-credit counter are 0; the skid buffer is empty.
- AW path: two-entry skid buffer (main plus overflow register).
  - Full throughput; 1-cycle latency from s handshake to m_axi_awvalid.
  - s_axi_awready is registered and equals "overflow register empty".
  - Payload is held stable while m_axi_awvalid=1 and m_axi_awready=0.
- Throttle:
  - m_axi_awvalid = buffer non-empty AND outstanding < MAX_OUTSTANDING.
  - When outstanding == MAX_OUTSTANDING, the AW stays buffered and upstream back-pressures once both skid entries are full.
- outstanding counter:
  - +1 on m AW handshake, -1 on s_axi B handshake.
  - Both in the same cycle: unchanged.
  - Never wraps; decrement at 0 is a protocol violation (assertion only, counter held).
- Burst credit counter, width 4:
  - +1 on m AW handshake, -1 on the m W handshake with wlast=1.
  - Both in the same cycle: unchanged.
  - Credit never exceeds outstanding.
- W path is combinational pass-through gated by credit:
  - m_axi_wvalid = s_axi_wvalid & (credit != 0).
  - s_axi_wready = m_axi_wready & (credit != 0).
  - Data, strb and last are passed straight through.
  - A beat whose AW handshake happens in the same cycle is not forwarded until the next cycle; credit updates are registered.
- B path is combinational pass-through: s_axi_bvalid = m_axi_bvalid, m_axi_bready = s_axi_bready, bresp passed through.
- err_sticky:
  - Set on a B handshake with bresp[1]=1, or with bresp=2'b01.
  - err_clear clears it; a set event in the same cycle wins.
- Reset mid-burst clears all state. Upstream and downstream must be reset together, since both share axi_aresetn.

Optional Feature:
- Macro AXI_HP_WR_THROTTLE_STATS_EN.
- Defined: adds outputs stat_bursts (32-bit, +1 per B handshake) and stat_beats (32-bit, +1 per m W handshake).
  - Both wrap modulo 2^32, clear on reset, and also clear on err_clear.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package axi_hp_wr_pkg holds:
  - AXI3 width constants (LEN_W=4, SIZE_W=3, BURST_W=2, PROT_W=3, CACHE_W=4, RESP_W=2).
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
  - A packed AW payload struct.
- One sub-module, axi_skid_buf (parameterised payload width), implements the AW two-entry skid.

Test Plan:
- Single burst (awlen=3, awready=1, wready=1, bvalid one cycle after wlast) -> m_axi_awvalid one cycle after s handshake; 4 W beats forwarded; outstanding goes 0->1->0.
- 6 back-to-back AWs with MAX_OUTSTANDING=4 and B withheld -> exactly 4 m AW handshakes; outstanding holds at 4; s_axi_awready drops after 2 more are buffered; releasing one B issues the 5th AW the next cycle.
- W presented 5 cycles before its AW -> m_axi_wvalid stays 0 until the cycle after the m AW handshake; no beat lost; s_axi_wready is 0 while blocked.
- B handshake and m AW handshake in the same cycle at outstanding=2 -> outstanding remains 2.
- bresp=2'b10 returned -> err_sticky=1 the next cycle; err_clear pulse -> 0; err_clear coincident with a new SLVERR -> stays 1.
- axi_aresetn low for 1 cycle mid-burst (credit=1, outstanding=2) -> all valids 0, outstanding=0, credit=0 the next cycle; stat counters read 0 when AXI_HP_WR_THROTTLE_STATS_EN is defined.
